// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_pkg
// Purpose : Shared definitions for the controller port: button bit indices,
//           the default open-bus pattern, the per-port state encoding and a
//           helper that orders a button byte into serial shift order.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // Button bit positions within a btnN byte (1 = pressed)
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Upper bits returned on a read; bit 0 is replaced by the serial bit
  localparam logic [7:0] OPEN_BUS_DEFAULT = 8'h40;

  // Serial bit position of the last button
  localparam logic [3:0] LAST_BIT_COUNT = 4'd7;
  localparam logic [3:0] DONE_COUNT     = 4'd8;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    SHIFT     = 2'd1,
    EXHAUSTED = 2'd2
  } port_state_t;

  // Place buttons so that shift-register bit k is the k-th bit sent out:
  // A, B, Select, Start, Up, Down, Left, Right.
  function automatic logic [7:0] serial_order(input logic [7:0] b);
    return {b[BTN_RIGHT], b[BTN_LEFT], b[BTN_DOWN], b[BTN_UP],
            b[BTN_START], b[BTN_SELECT], b[BTN_B], b[BTN_A]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/controller_shifter.sv
`default_nettype none
// ============================================================================
// Module  : controller_shifter
// Purpose : One controller port: holds the latest button byte, reloads its
//           shift register while strobe is high, and shifts one button out
//           per read once strobe drops. After 8 reads it returns
//           EXHAUSTED_BIT until the next strobe.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           strobe        - registered strobe from the port top
//           rd            - read of this port this cycle
//           btn/btn_valid - button byte and its one-cycle capture pulse
//           serial        - bit presented on a read of this port
// Revision: 1.0 - initial release
// ============================================================================
module controller_shifter
  import ctrl_pkg::*;
#(
  parameter logic EXHAUSTED_BIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe,
  input  logic       rd,
  input  logic [7:0] btn,
  input  logic       btn_valid,
  output logic       serial
);

  logic [7:0]  r_held;
  logic [7:0]  w_held_next;
  logic [7:0]  r_shreg;
  logic [7:0]  w_shreg_next;
  logic [3:0]  r_count;
  logic [3:0]  w_count_next;
  port_state_t r_state;
  port_state_t w_state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_held  <= 8'h00;
      r_shreg <= 8'h00;
      r_count <= DONE_COUNT;
      r_state <= EXHAUSTED;
    end else begin
      r_held  <= w_held_next;
      r_shreg <= w_shreg_next;
      r_count <= w_count_next;
      r_state <= w_state_next;
    end
  end

  always_comb begin
    // A valid pulse is visible in the same cycle (load bypass)
    w_held_next  = btn_valid ? btn : r_held;
    w_state_next = r_state;
    w_shreg_next = r_shreg;
    w_count_next = r_count;

    if (strobe) begin
      w_state_next = LOAD;
      w_shreg_next = serial_order(w_held_next);
      w_count_next = 4'd0;
    end else begin
      case (r_state)
        // LOAD with strobe already low behaves as SHIFT at count 0: the
        // register still holds the value loaded on the last strobe cycle.
        LOAD, SHIFT: begin
          w_state_next = SHIFT;
          if (rd) begin
            w_shreg_next = {1'b0, r_shreg[7:1]};
            w_count_next = r_count + 4'd1;
            if (r_count == LAST_BIT_COUNT) begin
              w_state_next = EXHAUSTED;
            end
          end
        end
        EXHAUSTED: begin
          w_count_next = DONE_COUNT;
        end
        default: begin
          w_state_next = EXHAUSTED;
          w_count_next = DONE_COUNT;
        end
      endcase
    end
  end

  always_comb begin
    serial = r_shreg[0];
    if (strobe) begin
      serial = w_held_next[BTN_A];
    end else if (r_state == EXHAUSTED) begin
      serial = EXHAUSTED_BIT;
    end
  end

endmodule
`default_nettype wire

// File: rtl/controller_port.sv
`default_nettype none
// ============================================================================
// Module  : controller_port
// Purpose : CPU-side joypad registers at $4016/$4017. Holds the strobe
//           register, decodes reads and writes, and drives the shared data
//           bus with the open-bus pattern plus the selected serial bit.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           cs              - active-low select from the address decoder
//           addr            - 0 = $4016 (port 1), 1 = $4017 (port 2)
//           rw              - 1 = CPU read, 0 = CPU write
//           cpubus          - shared bidirectional CPU data bus
//           btn1/btn2       - button bytes from the serial receivers
//           btn1_valid/btn2_valid - one-cycle pulses marking new bytes
// Revision: 1.0 - initial release
// ============================================================================
module controller_port
  import ctrl_pkg::*;
#(
  parameter logic [7:0] OPEN_BUS      = OPEN_BUS_DEFAULT,
  parameter logic       EXHAUSTED_BIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       addr,
  input  logic       rw,
  inout  wire  [7:0] cpubus,
  input  logic [7:0] btn1,
  input  logic [7:0] btn2,
  input  logic       btn1_valid,
  input  logic       btn2_valid
);

  logic       r_strobe;
  logic       w_rd;
  logic       w_wr;
  logic       w_rd1;
  logic       w_rd2;
  logic       w_serial1;
  logic       w_serial2;
  logic       w_serial;
  logic       w_bus_oe;
  logic [7:0] w_bus_out;

  // Reset overrides any access in the same cycle
  assign w_rd  = !rst && !cs && rw;
  assign w_wr  = !rst && !cs && !rw;
  assign w_rd1 = w_rd && !addr;
  assign w_rd2 = w_rd && addr;

  // Only $4016 writes reach the strobe; $4017 writes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_strobe <= 1'b0;
    end else if (w_wr && !addr) begin
      r_strobe <= cpubus[0];
    end
  end

  controller_shifter #(
    .EXHAUSTED_BIT (EXHAUSTED_BIT)
  ) u_shifter1 (
    .clk       (clk),
    .rst       (rst),
    .strobe    (r_strobe),
    .rd        (w_rd1),
    .btn       (btn1),
    .btn_valid (btn1_valid),
    .serial    (w_serial1)
  );

  controller_shifter #(
    .EXHAUSTED_BIT (EXHAUSTED_BIT)
  ) u_shifter2 (
    .clk       (clk),
    .rst       (rst),
    .strobe    (r_strobe),
    .rd        (w_rd2),
    .btn       (btn2),
    .btn_valid (btn2_valid),
    .serial    (w_serial2)
  );

  assign w_serial  = addr ? w_serial2 : w_serial1;
  assign w_bus_oe  = w_rd;
  assign w_bus_out = (OPEN_BUS & 8'hFE) | {7'b0, w_serial};
  assign cpubus    = w_bus_oe ? w_bus_out : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_controller_port.sv
`default_nettype none
// ============================================================================
// Module  : tb_controller_port
// Purpose : Self-checking bench for controller_port: directed scenarios
//           followed by random traffic, checked against a button-index
//           reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_controller_port;

  localparam logic [7:0] OB  = 8'h40;
  localparam logic       EXB = 1'b1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs = 1'b1;
  logic       addr = 1'b0;
  logic       rw = 1'b1;
  logic [7:0] btn1 = 8'h00;
  logic [7:0] btn2 = 8'h00;
  logic       btn1_valid = 1'b0;
  logic       btn2_valid = 1'b0;
  logic [7:0] drv_data = 8'h00;
  logic       drv_en = 1'b0;
  wire  [7:0] cpubus;

  assign cpubus = drv_en ? drv_data : 8'hzz;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] last_rd = 8'h00;

  // Reference model: latched byte plus index of the next button to send
  logic       m_strobe = 1'b0;
  logic [7:0] m_held  [2];
  logic [7:0] m_latch [2];
  int         m_idx   [2];

  always #5 clk = ~clk;

  controller_port #(
    .OPEN_BUS      (OB),
    .EXHAUSTED_BIT (EXB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cs         (cs),
    .addr       (addr),
    .rw         (rw),
    .cpubus     (cpubus),
    .btn1       (btn1),
    .btn2       (btn2),
    .btn1_valid (btn1_valid),
    .btn2_valid (btn2_valid)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic a, input logic w,
                      input logic [7:0] d, input logic v1, input logic [7:0] b1,
                      input logic v2, input logic [7:0] b2, input string tag);
    logic [7:0] hn [2];
    logic       exp_bit;
    logic [7:0] exp_byte;
    rst = r; cs = c; addr = a; rw = w;
    drv_data = d; drv_en = !c && !w;
    btn1_valid = v1; btn1 = b1; btn2_valid = v2; btn2 = b2;
    hn[0] = v1 ? b1 : m_held[0];
    hn[1] = v2 ? b2 : m_held[1];
    #4;
    if (!r && !c && w) begin
      if (m_strobe)            exp_bit = hn[a][0];
      else if (m_idx[a] >= 8)  exp_bit = EXB;
      else                     exp_bit = m_latch[a][m_idx[a]];
      exp_byte = (OB & 8'hFE) | {7'b0, exp_bit};
      last_rd = cpubus;
      chk(tag, cpubus, exp_byte);
    end else begin
      chk({tag, "_release"}, {7'b0, dut.w_bus_oe}, 8'h00);
    end
    if (r) begin
      m_strobe = 1'b0;
      for (int p = 0; p < 2; p++) begin
        m_held[p] = 8'h00; m_latch[p] = 8'h00; m_idx[p] = 8;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (m_strobe) begin
          m_latch[p] = hn[p];
          m_idx[p]   = 0;
        end else if (!c && w && (int'(a) == p) && m_idx[p] < 8) begin
          m_idx[p] = m_idx[p] + 1;
        end
        m_held[p] = hn[p];
      end
      if (!c && !w && !a) m_strobe = d[0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic a, input string tag);
    step(1'b0, 1'b0, a, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, tag);
  endtask

  task automatic wr(input logic a, input logic [7:0] d, input string tag);
    step(1'b0, 1'b0, a, 1'b0, d, 1'b0, 8'h00, 1'b0, 8'h00, tag);
  endtask

  task automatic pulse(input logic v1, input logic [7:0] b1, input logic v2,
                       input logic [7:0] b2, input string tag);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, v1, b1, v2, b2, tag);
  endtask

  initial begin
    logic [7:0] e31 [8];
    logic [7:0] e35 [8];
    e31 = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40};
    e35 = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40};
    m_held[0] = 8'h00; m_held[1] = 8'h00;
    m_latch[0] = 8'h00; m_latch[1] = 8'h00;
    m_idx[0] = 8; m_idx[1] = 8;

    @(posedge clk); #1;
    // Reset state
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, "reset");
    chk("rst_strobe", {7'b0, dut.r_strobe}, 8'h00);
    chk("rst_count1", {4'b0, dut.u_shifter1.r_count}, 8'd8);
    chk("rst_count2", {4'b0, dut.u_shifter2.r_count}, 8'd8);
    rd(1'b0, "post_rst_rd");
    chk("post_rst_41", last_rd, 8'h41);

    // Serial order of 8'h09, then exhaustion
    pulse(1'b1, 8'h09, 1'b0, 8'h00, "v1_09");
    wr(1'b0, 8'h01, "strobe_on");
    wr(1'b0, 8'h00, "strobe_off");
    for (int i = 0; i < 8; i++) begin
      rd(1'b0, "seq09_rd");
      chk("seq09_const", last_rd, e31[i]);
    end
    rd(1'b0, "rd9");
    chk("rd9_const", last_rd, 8'h41);
    rd(1'b0, "rd10");
    chk("rd10_const", last_rd, 8'h41);
    chk("rd10_count", {4'b0, dut.u_shifter1.r_count}, 8'd8);

    // Reads while strobe held high, then same-cycle valid bypass
    wr(1'b0, 8'h01, "strobe_hold");
    pulse(1'b1, 8'h00, 1'b0, 8'h00, "v1_00");
    for (int i = 0; i < 3; i++) begin
      rd(1'b0, "load_rd");
      chk("load_rd_const", last_rd, 8'h40);
    end
    chk("load_count", {4'b0, dut.u_shifter1.r_count}, 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, "bypass_rd");
    chk("bypass_const", last_rd, 8'h41);

    // Independent ports
    pulse(1'b1, 8'hFF, 1'b1, 8'h00, "v12");
    wr(1'b0, 8'h01, "strobe_on2");
    wr(1'b0, 8'h00, "strobe_off2");
    for (int i = 0; i < 8; i++) begin
      rd(1'b0, "alt_p1");
      chk("alt_p1_const", last_rd, 8'h41);
      rd(1'b1, "alt_p2");
      chk("alt_p2_const", last_rd, 8'h40);
    end

    // Re-strobe mid-shift restarts from A; $4017 write is ignored
    pulse(1'b1, 8'h0F, 1'b0, 8'h00, "v1_0F");
    wr(1'b0, 8'h01, "strobe_on3");
    wr(1'b0, 8'h00, "strobe_off3");
    for (int i = 0; i < 3; i++) rd(1'b0, "pre_restrobe");
    wr(1'b0, 8'h01, "restrobe_on");
    wr(1'b0, 8'h00, "restrobe_off");
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        wr(1'b1, 8'h01, "wr4017");
        chk("wr4017_strobe", {7'b0, dut.r_strobe}, 8'h00);
      end
      rd(1'b0, "restart_rd");
      chk("restart_const", last_rd, e35[i]);
    end

    // Reset mid-shift, with a read in the reset cycle
    pulse(1'b1, 8'hA5, 1'b1, 8'h3C, "v12_b");
    wr(1'b0, 8'h01, "strobe_on4");
    wr(1'b0, 8'h00, "strobe_off4");
    for (int i = 0; i < 3; i++) rd(1'b0, "pre_rst_rd");
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h77, 1'b0, 8'h00, "rst_mid");
    chk("rst_mid_count1", {4'b0, dut.u_shifter1.r_count}, 8'd8);
    chk("rst_mid_count2", {4'b0, dut.u_shifter2.r_count}, 8'd8);
    chk("rst_mid_strobe", {7'b0, dut.r_strobe}, 8'h00);
    pulse(1'b0, 8'h00, 1'b0, 8'h00, "idle_after_rst");
    rd(1'b0, "rd_after_rst");
    chk("rd_after_rst_const", last_rd, 8'h41);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic r, c, a, w, v1, v2;
      logic [7:0] d, b1, b2;
      r  = ($urandom_range(0, 59) == 0);
      c  = ($urandom_range(0, 4) == 0);
      a  = 1'($urandom_range(0, 1));
      w  = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom);
      v1 = ($urandom_range(0, 3) == 0);
      v2 = ($urandom_range(0, 3) == 0);
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      step(r, c, a, w, d, v1, b1, v2, b2, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/controller_port.md
CONTROLLER_PORT -- requirements
Module: controller_port

Interface
REQ-001 The module SHALL have the parameter OPEN_BUS, default 8'h40, which supplies the upper-bit pattern returned on reads with bit 0 zeroed.
REQ-002 The module SHALL have the parameter EXHAUSTED_BIT, default 1'b1, which is the serial bit returned once a port has shifted out all 8 buttons.
REQ-003 The module SHALL have port clk, input, width 1, the CPU-domain clock; this is the one clock and all state SHALL be on its rising edge.
REQ-004 The module SHALL have port rst, input, width 1; reset is synchronous and active-high.
REQ-005 The module SHALL have port cs, input, width 1, an active-low select from the hardware decoder.
REQ-006 The module SHALL have port addr, input, width 1, where 0 selects $4016 (port 1) and 1 selects $4017 (port 2).
REQ-007 The module SHALL have port rw, input, width 1, where 1 means CPU read and 0 means CPU write.
REQ-008 The module SHALL have port cpubus, inout, width 8, the shared CPU data bus.
REQ-009 The module SHALL have ports btn1 and btn2, input, width 8 each, the button bytes from the serial receivers, with bit0=A, bit1=B, bit2=Select, bit3=Start, bit4=Up, bit5=Down, bit6=Left, bit7=Right, and 1 meaning pressed.
REQ-010 The module SHALL have ports btn1_valid and btn2_valid, input, width 1 each, a one-cycle pulse marking a new btnN byte.

Function
REQ-011 On each btnN_valid pulse the module SHALL capture btnN into a held register held_N; held_N SHALL be unchanged otherwise.
REQ-012 A CPU write is cs=0 and rw=0; a write with addr=0 SHALL set strobe to cpubus[0] on the next edge, and a write with addr=1 SHALL be ignored.
REQ-013 Each port SHALL implement a state machine with states LOAD (strobe=1), SHIFT (count 0..7) and EXHAUSTED (count=8).
REQ-014 In LOAD, the port SHALL load its shift register from held_N every cycle and hold count at 0; if btnN_valid is high in the same cycle, the new btnN SHALL be loaded (bypass).
REQ-015 A strobe transition from 1 to 0 SHALL move the port from LOAD to SHIFT with the last loaded value and count=0.
REQ-016 A CPU read is cs=0 and rw=1; the selected port SHALL present serial bit shreg[0] combinationally during the read cycle.
REQ-017 In SHIFT, a read SHALL right-shift the selected port's register and increment its count at the end of the read cycle, and a read at count=7 SHALL move the port to EXHAUSTED.
REQ-018 Back-to-back reads on consecutive cycles SHALL each shift once.
REQ-019 In EXHAUSTED, a read SHALL return EXHAUSTED_BIT and SHALL leave count saturated at 8.
REQ-020 In LOAD, a read SHALL return held_N[0] (A) with no shift.
REQ-021 A read SHALL affect only the addressed port; the other port SHALL hold its state.
REQ-022 A write with strobe=1 SHALL move both ports to LOAD from any state, including mid-shift.
REQ-023 During a read the module SHALL drive cpubus = OPEN_BUS | {7'b0, serial_bit}, and SHALL release cpubus to high-Z at all other times, including during writes.
REQ-024 When cs=1, a read, write or shift SHALL not occur.

Reset
REQ-025 On rst, the module SHALL set strobe=0, held_1 and held_2 to 8'h00, both shift registers to 8'h00, and both counts to 8 (EXHAUSTED).
REQ-026 On rst, the module SHALL release cpubus; a read immediately after reset SHALL return 8'h41.
REQ-027 rst SHALL take priority over valid pulses and over any CPU access in the same cycle.

Structure
REQ-028 A shared package ctrl_pkg SHALL hold the button bit-index constants, OPEN_BUS_DEFAULT, and the state encoding (LOAD, SHIFT, EXHAUSTED).
REQ-029 The module SHALL contain one sub-module, controller_shifter, instantiated twice (one per port), containing held register, shift register, count and state.
REQ-030 The top of controller_port SHALL contain the strobe register, read/write decode and bus driver.

Verification
REQ-031 The bench SHALL apply btn1=8'h09 with a valid pulse, write 8'h01 then 8'h00 to $4016, then 8 reads of $4016, and SHALL see returns 41,40,40,41,40,40,40,40.
REQ-032 Continuing from REQ-031, the bench SHALL perform reads 9 and 10, and SHALL see 8'h41 on each with count held at 8.
REQ-033 The bench SHALL leave strobe=1 with held_1=8'h00 and read $4016 three times, and SHALL see 8'h40 each time with no shift; it SHALL then pulse btn1_valid with 8'h01 in the same cycle as a read and see 8'h41.
REQ-034 The bench SHALL load btn1=8'hFF and btn2=8'h00, strobe, then alternate $4016/$4017 reads, and SHALL see port 1 return 41 and port 2 return 40 each time, independently for 8 reads each.
REQ-035 The bench SHALL re-strobe with 8'h01 after 3 reads of 8'h0F and then clear strobe, and SHALL see reads restart from bit0 (41,41,41,41,40...); it SHALL also write to $4017 and see no state change.
REQ-036 The bench SHALL assert rst mid-shift, and SHALL see count=8 and strobe=0 on the next cycle, cpubus high-Z with no read, and the next read return 8'h41.
